// File: rtl/uio_bus_arbiter.sv
// uio_bus_arbiter: round-robin owner of the uio pads with bounded bursts and a turnaround after driven bursts.
module uio_bus_arbiter #(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 8,
  parameter int BURST_W   = $clog2(MAX_BURST + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         dir,
  input  logic [NREQ-1:0]         last,
  input  logic [8*NREQ-1:0]       wdata,
  input  logic [7:0]              uio_in,
  output logic [7:0]              uio_out,
  output logic [7:0]              uio_oe,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] gnt_id,
  output logic [7:0]              rdata,
  output logic                    rvalid
);
  localparam int IW = $clog2(NREQ);
  localparam logic [BURST_W-1:0] MAXB = BURST_W'(MAX_BURST);
  typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, owner_q, owner_d, pick, idx;
  logic [BURST_W-1:0] cnt_q, cnt_d;
  logic dir_q, dir_d, rvalid_q, rvalid_d, found, beat;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [7:0] rdata_q, rdata_d;
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    dir_d    = dir_q;
    gnt_d    = gnt_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    found    = 1'b0;
    pick     = '0;
    idx      = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IW'((int'(ptr_q) + k) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    beat = state_q == OWN && req[owner_q] && ena;
    if (state_q == IDLE && ena && found) begin
      state_d = OWN;
      owner_d = pick;
      dir_d   = dir[pick];
      cnt_d   = '0;
      gnt_d   = NREQ'(1) << pick;
    end else if (state_q == OWN) begin
      cnt_d = beat ? cnt_q + BURST_W'(1) : cnt_q;
      if (beat && !dir_q) begin
        rvalid_d = 1'b1;
        rdata_d  = uio_in;
      end
      // no beat covers both a dropped request and a disabled design
      if (!beat || last[owner_q] || cnt_d == MAXB) begin
        gnt_d   = '0;
        ptr_d   = owner_q == IW'(NREQ - 1) ? '0 : owner_q + IW'(1);
        state_d = dir_q ? TURN : IDLE;
      end
    end else if (state_q == TURN) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      owner_q  <= '0;
      dir_q    <= 1'b0;
      gnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      dir_q    <= dir_d;
      gnt_q    <= gnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end
  assign uio_oe  = {8{state_q == OWN && dir_q}};
  assign uio_out = uio_oe & wdata[8*owner_q +: 8];
  assign gnt     = gnt_q;
  assign gnt_id  = owner_q;
  assign rdata   = rdata_q;
  assign rvalid  = rvalid_q;
endmodule

// File: tb/tb_uio_bus_arbiter.sv
// tb_uio_bus_arbiter: directed and random stimulus checked every cycle against a burst-level reference model.
module tb_uio_bus_arbiter;
  localparam int N  = 4;
  localparam int MB = 4;
  logic clk = 1'b0;
  logic rst = 1'b1, ena = 1'b1;
  logic [N-1:0] req = '1, dir = '0, last = '0;
  logic [8*N-1:0] wdata = '0;
  logic [7:0] uio_in = '0, uio_out, uio_oe, rdata;
  logic [N-1:0] gnt;
  logic [1:0] gnt_id;
  logic rvalid;
  int n_chk = 0, n_fail = 0;
  int m_owner = -1, m_ptr = 0, m_cool = 0, m_beats = 0;
  bit m_dir = 0, m_rv = 0;
  logic [7:0] m_rd = '0;
  logic [N-1:0] rq;
  uio_bus_arbiter #(.NREQ(N), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .ena(ena), .req(req), .dir(dir), .last(last),
    .wdata(wdata), .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe),
    .gnt(gnt), .gnt_id(gnt_id), .rdata(rdata), .rvalid(rvalid)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_outputs();
    logic [7:0] oe, dat;
    oe  = (m_owner >= 0 && m_dir) ? 8'hFF : 8'h00;
    dat = (m_owner >= 0 && m_dir) ? 8'((wdata >> (8 * m_owner)) & 32'hFF) : 8'h00;
    chk("gnt", 32'(gnt), m_owner >= 0 ? 32'(1 << m_owner) : 32'd0);
    if (m_owner >= 0) chk("gnt_id", 32'(gnt_id), 32'(m_owner));
    chk("uio_oe", 32'(uio_oe), 32'(oe));
    chk("uio_out", 32'(uio_out), 32'(dat));
    chk("rvalid", 32'(rvalid), 32'(m_rv));
    chk("rdata", 32'(rdata), 32'(m_rd));
  endtask
  // Burst-level view: who owns the pads, how many beats so far, and how many dead cycles remain before arbitration.
  task automatic model_edge();
    bit b;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_cool = 0; m_rv = 0; m_rd = '0;
    end else if (m_owner >= 0) begin
      b = req[m_owner] && ena;
      m_rv = b && !m_dir;
      if (m_rv) m_rd = uio_in;
      if (b) m_beats++;
      if (!b || last[m_owner] || m_beats == MB) begin
        m_ptr = (m_owner + 1) % N;
        m_cool = m_dir ? 1 : 0;
        m_owner = -1;
      end
    end else begin
      m_rv = 0;
      if (m_cool > 0) m_cool--;
      else if (ena) begin
        for (int k = 0; k < N; k++) begin
          int i;
          i = (m_ptr + k) % N;
          if (req[i]) begin
            m_owner = i; m_dir = dir[i]; m_beats = 0;
            break;
          end
        end
      end
    end
  endtask
  task automatic cyc(input bit r, input bit e, input logic [N-1:0] q, input logic [N-1:0] d, input logic [N-1:0] l);
    rst = r; ena = e; req = q; dir = d; last = l;
    wdata = $urandom; uio_in = 8'($urandom);
    #1 check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    repeat (2) cyc(1, 1, 4'hF, 4'h0, 4'h0);
    repeat (3) cyc(0, 1, 4'hF, 4'h0, 4'h1);
    repeat (3) cyc(0, 1, 4'h0, 4'h0, 4'h0);
    repeat (3) cyc(0, 1, 4'h1, 4'h1, 4'h0);
    cyc(0, 1, 4'h1, 4'h1, 4'h1);
    repeat (3) cyc(0, 1, 4'h0, 4'h0, 4'h0);
    repeat (24) cyc(0, 1, 4'hF, 4'h0, 4'h0);
    repeat (2) cyc(0, 1, 4'h0, 4'h0, 4'h0);
    repeat (3) cyc(0, 1, 4'h4, 4'h0, 4'h0);
    cyc(0, 1, 4'h4, 4'h0, 4'h4);
    repeat (2) cyc(0, 1, 4'h0, 4'h0, 4'h0);
    repeat (2) cyc(0, 1, 4'h2, 4'h2, 4'h0);
    cyc(1, 1, 4'h2, 4'h2, 4'h0);
    repeat (3) cyc(0, 1, 4'hA, 4'hF, 4'h0);
    repeat (3) cyc(0, 1, 4'h0, 4'h0, 4'h0);
    cyc(1, 1, 4'h0, 4'h0, 4'h0);
    repeat (2) cyc(0, 1, 4'h1, 4'h1, 4'h0);
    repeat (3) cyc(0, 0, 4'h3, 4'h3, 4'h0);
    repeat (3) cyc(0, 1, 4'h3, 4'h3, 4'h0);
    repeat (4) cyc(0, 1, 4'h0, 4'h0, 4'h0);
    rq = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
      cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 95, rq,
          4'($urandom), 4'($urandom & $urandom));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uio_bus_arbiter.md
Name: uio_bus_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the 8-bit bidirectional uio pad group of the TinyTapeout top among NREQ internal requesters.
- Each requester gets exclusive, bounded-length ownership of the pads in either drive (output) or sample (input) direction.
- The block owns uio_out/uio_oe and inserts a mandatory turnaround cycle after any driven burst, so two owners never drive back to back.
- Instantiated inside tt_um_Xelef2000, between the internal function units and the uio pins.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MAX_BURST, 8, maximum beats per ownership before forced release (>=1).
- BURST_W, $clog2(MAX_BURST+1), width of the internal beat counter (derived).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- ena  input  1  design enable; low forces release and blocks new grants.
- req  input  NREQ  per-requester request, level; held for the whole burst.
- dir  input  NREQ  per-requester direction, 1=drive pads, 0=sample pads; latched at grant.
- last  input  NREQ  per-requester final-beat marker.
- wdata  input  8*NREQ  requester i drive data on bits [8i+7:8i].
- uio_in  input  8  pad input path.
- uio_out  output  8  pad output data.
- uio_oe  output  8  pad output enable, 8'hFF or 8'h00 only.
- gnt  output  NREQ  one-hot grant, registered.
- gnt_id  output  $clog2(NREQ)  index of current owner; valid while gnt!=0.
- rdata  output  8  registered sample of uio_in.
- rvalid  output  1  one-cycle strobe, rdata valid.

Behaviour:
- Reset (rst=1 at edge):
  - state=IDLE, ptr=0, beat counter=0, owner=0, dir_q=0.
  - Outputs: gnt=0, gnt_id=0, uio_out=0, uio_oe=0, rdata=0, rvalid=0.
  - Reset overrides every other event, including mid-burst; the bus is released on the next cycle with no turnaround.
- States: IDLE, OWN, TURN.
- IDLE:
  - gnt=0, uio_oe=0.
  - If ena=1 and any req: pick the first asserted req[i] scanning ptr, ptr+1, ..., ptr+NREQ-1 (mod NREQ).
  - Register owner=i, dir_q=dir[i], beat counter=0, gnt=one-hot(i); go to OWN.
  - Grant latency is 1 cycle: req high at edge k gives gnt high in cycle k+1.
- OWN, outputs:
  - uio_oe=8'hFF when dir_q=1, else 8'h00.
  - uio_out = wdata[owner] when dir_q=1, else 8'h00 (combinational from registered owner/dir_q).
- OWN, beats:
  - Beat = OWN cycle with req[owner]=1 and ena=1; the counter increments on each beat.
  - Input beat (dir_q=0): rdata<=uio_in, rvalid<=1 at that edge, so rvalid is high the following cycle. rvalid=0 otherwise.
- OWN, release: at the edge where any of the following holds:
  - (a) req[owner]=0: no beat, no rvalid; bus was still driven that cycle if dir_q=1.
  - (b) beat with last[owner]=1.
  - (c) beat that makes the counter reach MAX_BURST.
  - (d) ena=0: no beat.
- On release:
  - gnt<=0, ptr<=owner+1 mod NREQ.
  - Next state TURN if dir_q=1, else IDLE.
- TURN:
  - Exactly 1 cycle, uio_oe=0, uio_out=0, gnt=0, no grant evaluated; then IDLE.
- Gap between owners:
  - Input bursts: 1 IDLE cycle.
  - Output bursts: TURN + IDLE = 2 cycles.
- Ownership rules:
  - dir/req of non-owners are ignored during OWN; a dir change by the owner mid-burst is ignored.
  - A requester keeping req high after release re-competes; round-robin guarantees the others go first.
- rvalid from the final input beat appears in the first post-release cycle; this is legal.

Test Plan:
- Reset: rst=1 for 2 cycles with req=4'b1111, ena=1 -> gnt=0, uio_oe=00, rvalid=0 throughout; after rst drops, gnt=0001 one cycle later.
- Single writer: req0=1, dir0=1, wdata0=8'hA5, last0 on 3rd beat -> gnt=0001 one cycle after req; uio_oe=FF, uio_out=A5 for 3 cycles; then 1 TURN cycle with uio_oe=00, gnt=0; then IDLE.
- Round robin: req=1111, dir=0, last=0, MAX_BURST=4 -> owners 0,1,2,3,0; each has 4 OWN cycles separated by 1 IDLE cycle; gnt_id follows 0,1,2,3,0.
- Reader: req2 alone, dir2=0, uio_in=11,22,33 on beats 1..3, last on beat 3 -> rdata=11,22,33 with rvalid=1 one cycle after each beat; uio_oe=00 always; no TURN.
- Reset mid-burst: req1 writing, rst pulsed on beat 2 -> next cycle uio_oe=00, gnt=0; with req1 and req3 then high, req1 is granted first (ptr=0).
- Enable drop: req0 writing, ena=0 on beat 2 -> release at that edge, TURN next cycle, no grants while ena=0; ena=1 with req0 and req1 high -> req1 granted (ptr=1).
